// File: rtl/final_cpa_pipe_if.sv
// Row-pair / result handshake bundle for the final carry-propagate adder.
// The slave side is the adder itself; the master side is its environment
// (compressor tree upstream plus result consumer downstream).
interface final_cpa_pipe_if #(
  parameter int W = 16
);
  logic         i_VALID;
  logic         o_READY;
  logic [W-1:0] i_S;
  logic [W-1:0] i_C;
  logic         o_VALID;
  logic         i_READY;
  logic [W-1:0] o_P;
  logic         o_COUT;

  modport slave (
    input  i_VALID, i_S, i_C, i_READY,
    output o_READY, o_VALID, o_P, o_COUT
  );

  modport master (
    output i_VALID, i_S, i_C, i_READY,
    input  o_READY, o_VALID, o_P, o_COUT
  );
endinterface

// File: rtl/final_cpa_pipe.sv
// Final carry-propagate adder behind the 4-2 compressor tree.
// Adds the sum and carry rows in two pipeline stages split at W/2: the lower
// half is added in stage 1, the upper half plus the lower carry in stage 2.
// Valid/ready handshake on both sides; holds at most two items when stalled.
module final_cpa_pipe #(
  parameter int W = 16
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  final_cpa_pipe_if.slave pipe_if
);

  localparam int L = W / 2;
  localparam int H = W - L;

  // Lower-half add, carry returned in the top bit.
  function automatic logic [L:0] add_lo(input logic [L-1:0] a, input logic [L-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Upper-half add with carry-in from the lower half, carry-out in the top bit.
  function automatic logic [H:0] add_hi(input logic [H-1:0] a, input logic [H-1:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {{H{1'b0}}, cin};
  endfunction

  logic         vld_p1_q;
  logic         c1_p1_q;
  logic [L-1:0] pl_p1_q;
  logic [H-1:0] su_p1_q;
  logic [H-1:0] cu_p1_q;

  logic         vld_p2_q;
  logic [W-1:0] p_p2_q;
  logic         cout_p2_q;

  logic         en1;
  logic         en2;
  logic [L:0]   lo_d;
  logic [H:0]   hi_d;

  // Stage enables and the two half-width adders.
  always_comb begin
    en2  = ~vld_p2_q | pipe_if.i_READY;
    en1  = ~vld_p1_q | en2;
    lo_d = add_lo(pipe_if.i_S[L-1:0], pipe_if.i_C[L-1:0]);
    hi_d = add_hi(su_p1_q, cu_p1_q, c1_p1_q);
  end

  assign pipe_if.o_READY = en1;
  assign pipe_if.o_VALID = vld_p2_q;
  assign pipe_if.o_P     = p_p2_q;
  assign pipe_if.o_COUT  = cout_p2_q;

  // ---- stage 1: lower-half sum, upper operands parked ----

  // Stage 1 occupancy; reset empties it.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      vld_p1_q <= 1'b0;
    end else if (en1) begin
      vld_p1_q <= pipe_if.i_VALID;
    end
  end

  // Stage 1 data; only written when a real item is accepted, stale otherwise.
  always_ff @(posedge i_CLK) begin
    if (en1 && pipe_if.i_VALID) begin
      {c1_p1_q, pl_p1_q} <= lo_d;
      su_p1_q            <= pipe_if.i_S[W-1:L];
      cu_p1_q            <= pipe_if.i_C[W-1:L];
    end
  end

  // ---- stage 2: upper-half sum with lower carry, result register ----

  // Result register; cleared on reset so the output bus reads zero.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      vld_p2_q  <= 1'b0;
      p_p2_q    <= '0;
      cout_p2_q <= 1'b0;
    end else if (en2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        {cout_p2_q, p_p2_q[W-1:L]} <= hi_d;
        p_p2_q[L-1:0]              <= pl_p1_q;
      end
    end
  end

endmodule

// File: tb/tb_final_cpa_pipe.sv
// Bench for final_cpa_pipe: directed cases plus randomized handshaking,
// checked against a queue model of accepted row pairs and their sums.
module tb_final_cpa_pipe;

  localparam int W = 16;

  logic clk;
  logic rst;

  final_cpa_pipe_if #(.W(W)) bus ();

  final_cpa_pipe #(.W(W)) dut (
    .i_CLK  (clk),
    .i_RST  (rst),
    .pipe_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: items accepted but not yet delivered, with their accept cycle.
  logic [W:0] exp_q[$];
  int         age_q[$];
  int         cyc = 0;
  logic [W:0] last_out;
  logic       prev_stall = 1'b0;
  logic [W:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs mid-cycle,
  // then update the model with the handshakes that happen at the next rising edge.
  task automatic step(input logic v, input logic [W-1:0] s, input logic [W-1:0] c,
                      input logic r, output logic acc);
    logic [W:0] exp_v;
    logic       exp_ovld;
    logic [W:0] obs;
    @(negedge clk);
    bus.i_VALID = v;
    bus.i_S     = s;
    bus.i_C     = c;
    bus.i_READY = r;
    #1;
    obs      = {bus.o_COUT, bus.o_P};
    exp_ovld = (exp_q.size() > 0) && (cyc >= age_q[0] + 2);
    chk("o_VALID", 32'(bus.o_VALID), 32'(exp_ovld));
    chk("o_READY", 32'(bus.o_READY), 32'((exp_q.size() < 2) || r));
    if (prev_stall) chk("stall_hold", 32'(obs), 32'(prev_out));
    if (bus.o_VALID && r) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(obs), 32'h1_FFFF_FFF);
      end else begin
        exp_v = exp_q.pop_front();
        void'(age_q.pop_front());
        chk("data", 32'(obs), 32'(exp_v));
        last_out = obs;
      end
    end
    prev_stall = bus.o_VALID && !r;
    prev_out   = obs;
    acc = v && bus.o_READY;
    if (acc) begin
      exp_q.push_back({1'b0, s} + {1'b0, c});
      age_q.push_back(cyc);
    end
    cyc++;
  endtask

  // Reset for one rising edge, then check the cleared state.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.i_VALID = 1'b0;
    bus.i_S     = '0;
    bus.i_C     = '0;
    bus.i_READY = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    age_q.delete();
    prev_stall = 1'b0;
    chk("rst_o_VALID", 32'(bus.o_VALID), 32'd0);
    chk("rst_o_P",     32'(bus.o_P),     32'd0);
    chk("rst_o_COUT",  32'(bus.o_COUT),  32'd0);
    chk("rst_o_READY", 32'(bus.o_READY), 32'd1);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, a);
  endtask

  initial begin
    logic         a;
    logic         pend;
    logic         v;
    logic         r;
    logic [W-1:0] rs;
    logic [W-1:0] rc;
    int           idx;
    int           budget;

    rst         = 1'b1;
    bus.i_VALID = 1'b0;
    bus.i_S     = '0;
    bus.i_C     = '0;
    bus.i_READY = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Carry across the W/2 split.
    last_out = '1;
    step(1'b1, 16'h00FF, 16'h0001, 1'b1, a);
    chk("split_acc", 32'(a), 32'd1);
    idle(3);
    chk("split_result", 32'(last_out), 32'h0_0100);

    // Full-width overflow into o_COUT.
    last_out = '1;
    step(1'b1, 16'hFFFF, 16'h0001, 1'b1, a);
    idle(3);
    chk("ovf_ffff", 32'(last_out), 32'h1_0000);
    last_out = '1;
    step(1'b1, 16'h8000, 16'h8000, 1'b1, a);
    idle(3);
    chk("ovf_8000", 32'(last_out), 32'h1_0000);

    // Back-to-back streaming, one accept per cycle.
    last_out = '1;
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, 16'(n), 16'(3 * n), 1'b1, a);
      chk("stream_acc", 32'(a), 32'd1);
    end
    idle(3);
    chk("stream_last", 32'(last_out), 32'd32);

    // Backpressure: five stalled cycles, then release.
    last_out = '1;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'(idx + 1), 16'(idx + 1), 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_hold_P",  32'(bus.o_P), 32'd2);
    budget = 0;
    while ((idx < 3 || exp_q.size() > 0) && budget < 20) begin
      step(idx < 3, 16'(idx + 1), 16'(idx + 1), 1'b1, a);
      if (a) idx++;
      budget++;
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_last",    32'(last_out), 32'd6);

    // Reset with an item in flight; it must never come out.
    step(1'b1, 16'd5, 16'd5, 1'b1, a);
    chk("rstmid_acc", 32'(a), 32'd1);
    do_reset();
    last_out = '1;
    step(1'b1, 16'd7, 16'd1, 1'b1, a);
    idle(3);
    chk("rstmid_next", 32'(last_out), 32'd8);

    // Randomized traffic with random valid and ready; data held until accepted.
    pend = 1'b0;
    rs   = '0;
    rc   = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        if (v) begin
          rs   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
          rc   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
          pend = 1'b1;
        end
      end
      r = ($urandom_range(0, 3) != 0);
      step(pend, rs, rc, r, a);
      if (a) pend = 1'b0;
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      step(1'b0, '0, '0, 1'b1, a);
      budget++;
    end
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/final_cpa_pipe.md
Name: final_cpa_pipe

Overview:
- Final carry-propagate adder placed directly downstream of the 4-2 compressor tree.
- Takes the two residual rows (sum row, carry row) the tree produces and adds them into the final binary product.
- Two-stage pipeline, split at W/2, with valid/ready handshake on both sides.
- Exists so the tree's combinational depth plus a full-width ripple does not land in one cycle.

Parameters:
- W, 16, operand/result width in bits; must be even and >= 4. Lower half L = W/2.

Ports:
- i_CLK  in  1  clock; all state updates on rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_VALID  in  1  upstream row pair valid
- o_READY  out  1  block can accept the row pair this cycle
- i_S  in  W  sum row from compressor tree
- i_C  in  W  carry row from compressor tree, already weight-aligned by tree wiring; no shift applied here
- o_VALID  out  1  result valid
- i_READY  in  1  downstream accepts result
- o_P  out  W  (i_S + i_C) mod 2^W
- o_COUT  out  1  carry out of bit W-1

Behaviour:
- Pipeline state:
  - Stage 1 registers: v1, lower sum PL[L-1:0], lower carry c1, upper operands SU = i_S[W-1:L] and CU = i_C[W-1:L].
  - Stage 2 registers: v2, o_P, o_COUT.
- Enables:
  - en2 = ~v2 | i_READY
  - en1 = ~v1 | en2
  - o_READY = en1 (combinational from state and i_READY; no path from i_VALID)
- Stage 1 load (en1 = 1):
  - v1 <= i_VALID.
  - When i_VALID = 1: {c1, PL} <= i_S[L-1:0] + i_C[L-1:0] as an (L+1)-bit add, and SU/CU are captured.
  - Data registers may hold stale values when v1 = 0.
- Stage 2 load (en2 = 1):
  - v2 <= v1.
  - When v1 = 1: {o_COUT, o_P[W-1:L]} <= SU + CU + c1 as an (L+1)-bit add, and o_P[L-1:0] <= PL.
- o_VALID = v2.
- Latency: input accepted at edge k gives o_VALID = 1 after edge k+1, assuming no stall.
- Throughput: one result per cycle while i_READY = 1.
- Backpressure:
  - While o_VALID = 1 and i_READY = 0, o_P and o_COUT hold stable.
  - Stage 1 keeps filling if empty; then o_READY drops to 0.
  - A full stall holds at most 2 items, with no loss or duplication.
- Simultaneous events: with both stages full and i_READY = 1, o_READY = 1 in the same cycle. Stage 2 drains, stage 1 shifts into stage 2, and a new input enters stage 1, all at the same edge.
- Handshake rule: upstream must hold i_S/i_C/i_VALID stable until accepted (i_VALID & o_READY). The block does not check this.
- Arithmetic is unsigned and modulo 2^W. The bit-W carry is reported only via o_COUT. No approximation is applied in this block.
- Reset:
  - i_RST = 1 at an edge forces v1 = 0, v2 = 0, o_P = 0, o_COUT = 0, regardless of enables.
  - Other data registers are don't-care.
  - o_READY = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight items; none reappear afterwards.
  - Reset has priority over any simultaneous load.

Test Plan:
- Split-boundary carry: W=16, i_S=16'h00FF, i_C=16'h0001, i_READY=1 -> 2 cycles later o_VALID=1, o_P=16'h0100, o_COUT=0.
- Full overflow: i_S=16'hFFFF, i_C=16'h0001 -> o_P=16'h0000, o_COUT=1. Also i_S=16'h8000, i_C=16'h8000 -> o_P=16'h0000, o_COUT=1.
- Back-to-back streaming: 8 consecutive pairs (n, 3n), n=1..8, with i_READY=1 -> o_VALID high for 8 consecutive cycles starting 2 cycles after the first accept, o_P = 4n in order, o_READY held 1 throughout.
- Backpressure:
  - Setup: i_READY=0 for 5 cycles while i_VALID=1 with pairs (1,1), (2,2), (3,3).
  - Expected during stall: o_READY falls to 0 after 2 accepts; o_P=2 held stable.
  - Expected on release (i_READY=1): outputs 2, 4, 6 in order, no gaps beyond pipeline refill, no duplicates.
- Reset mid-flight: accept (5,5), assert i_RST one cycle later for 1 cycle -> o_VALID=0, o_P=0, o_COUT=0 after the reset edge; value 10 never appears; the next accepted pair (7,1) yields o_P=8 with latency 2.
- Random: 10k random W=16 pairs with random i_VALID/i_READY toggling -> scoreboard against (i_S+i_C) over 17 bits, exact order, zero mismatches.
